id_fwd_stage: RTL and testbench

ID_FWD_STAGE -- requirements
Module: id_fwd_stage

---
 rtl/id_fwd_stage.sv | 112 +++++++++++
 tb/tb_id_fwd_stage.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/id_fwd_stage.sv
// id_fwd_stage: decode stage with register file, operand forwarding, hazard stall,
// branch resolution and the ID/EX pipeline register.
module id_fwd_stage #(
  parameter int DW = 32,
  parameter int NSRC = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        wa,
  input  logic [2:0]        tuse_rs,
  input  logic [2:0]        tuse_rt,
  input  logic [2:0]        tnew,
  input  logic [2:0]        br_op,
  input  logic [DW-1:0]     imm,
  input  logic [DW-1:0]     pc,
  input  logic              ex_hold,
  input  logic              flush,
  input  logic              wb_we,
  input  logic [4:0]        wb_addr,
  input  logic [DW-1:0]     wb_data,
  input  logic [NSRC*5-1:0] src_addr,
  input  logic [NSRC*3-1:0] src_tnew,
  input  logic [NSRC*DW-1:0] src_data,
  output logic              stall,
  output logic              redirect,
  output logic [DW-1:0]     redirect_pc,
  output logic              ex_valid,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_wa,
  output logic [2:0]        ex_tnew,
  output logic [DW-1:0]     ex_rs_data,
  output logic [DW-1:0]     ex_rt_data,
  output logic [DW-1:0]     ex_imm,
  output logic [DW-1:0]     ex_pc
);
  typedef struct packed {
    logic          valid;
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic [4:0]    wa;
    logic [2:0]    tnew;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [DW-1:0] imm;
    logic [DW-1:0] pc;
  } ex_t;
  logic [DW-1:0] rf_q [32];
  logic [4:0]    sel [2];
  logic [2:0]    tuse [2];
  logic [DW-1:0] opnd [2];
  logic          hit [2];
  logic [2:0]    tn [2];
  logic          haz [2];
  logic          cond;
  ex_t           ex_d, ex_q;
  // Sources are scanned oldest-first so the youngest match overwrites earlier ones.
  always_comb begin
    sel[0] = rs;
    sel[1] = rt;
    tuse[0] = tuse_rs;
    tuse[1] = tuse_rt;
    for (int o = 0; o < 2; o++) begin
      opnd[o] = sel[o] == 5'd0 ? '0 : (wb_we && wb_addr == sel[o]) ? wb_data : rf_q[sel[o]];
      hit[o] = 1'b0;
      tn[o] = 3'd0;
      for (int i = NSRC - 1; i >= 0; i--)
        if (sel[o] != 5'd0 && src_addr[i*5 +: 5] == sel[o]) begin
          hit[o] = 1'b1;
          tn[o] = src_tnew[i*3 +: 3];
          if (src_tnew[i*3 +: 3] == 3'd0) opnd[o] = src_data[i*DW +: DW];
        end
      haz[o] = hit[o] && tuse[o] != 3'd7 && tn[o] > tuse[o];
    end
  end
  assign stall = in_valid && (haz[0] || haz[1]);
  always_comb begin
    cond = br_op == 3'd1 ? opnd[0] == opnd[1] :
           br_op == 3'd2 ? opnd[0] != opnd[1] :
           br_op == 3'd3 ? opnd[0][DW-1] || opnd[0] == '0 :
           br_op == 3'd4 ? !opnd[0][DW-1] && opnd[0] != '0 :
           br_op == 3'd5 ? opnd[0][DW-1] :
           br_op == 3'd6 ? !opnd[0][DW-1] :
           br_op == 3'd7;
    redirect = in_valid && !stall && !flush && !ex_hold && !reset && cond;
    redirect_pc = !redirect ? '0 : br_op == 3'd7 ? opnd[0] : pc + DW'(4) + (imm << 2);
    ex_d = ex_hold ? ex_q :
           (stall || flush || !in_valid) ? '0 :
           ex_t'{1'b1, rs, rt, wa, tnew, opnd[0], opnd[1], imm, pc};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q <= '0;
      for (int k = 0; k < 32; k++) rf_q[k] <= '0;
    end else begin
      ex_q <= ex_d;
      if (wb_we && wb_addr != 5'd0) rf_q[wb_addr] <= wb_data;
    end
  end
  assign ex_valid   = ex_q.valid;
  assign ex_rs      = ex_q.rs;
  assign ex_rt      = ex_q.rt;
  assign ex_wa      = ex_q.wa;
  assign ex_tnew    = ex_q.tnew;
  assign ex_rs_data = ex_q.rs_data;
  assign ex_rt_data = ex_q.rt_data;
  assign ex_imm     = ex_q.imm;
  assign ex_pc      = ex_q.pc;
endmodule

// File: tb/tb_id_fwd_stage.sv
// tb_id_fwd_stage: directed vectors with hand-computed expectations for id_fwd_stage.
module tb_id_fwd_stage;
  logic        clk, reset, in_valid, ex_hold, flush, wb_we;
  logic [4:0]  rs, rt, wa, wb_addr;
  logic [2:0]  tuse_rs, tuse_rt, tnew, br_op;
  logic [31:0] imm, pc, wb_data;
  logic [14:0] src_addr;
  logic [8:0]  src_tnew;
  logic [95:0] src_data;
  logic        stall, redirect, ex_valid;
  logic [31:0] redirect_pc, ex_rs_data, ex_rt_data, ex_imm, ex_pc;
  logic [4:0]  ex_rs, ex_rt, ex_wa;
  logic [2:0]  ex_tnew;
  int n_chk = 0;
  int n_fail = 0;

  id_fwd_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .rs(rs), .rt(rt), .wa(wa),
    .tuse_rs(tuse_rs), .tuse_rt(tuse_rt), .tnew(tnew), .br_op(br_op), .imm(imm), .pc(pc),
    .ex_hold(ex_hold), .flush(flush), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .src_addr(src_addr), .src_tnew(src_tnew), .src_data(src_data),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_wa(ex_wa), .ex_tnew(ex_tnew),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_pc(ex_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    reset = 0; in_valid = 0; ex_hold = 0; flush = 0; wb_we = 0;
    rs = 0; rt = 0; wa = 0; wb_addr = 0; tuse_rs = 3'd7; tuse_rt = 3'd7;
    tnew = 0; br_op = 0; imm = 0; pc = 0; wb_data = 0;
    src_addr = '0; src_tnew = '0; src_data = '0;
  endtask

  task automatic src(input int i, input logic [4:0] a, input logic [2:0] t, input logic [31:0] d);
    src_addr[i*5 +: 5] = a;
    src_tnew[i*3 +: 3] = t;
    src_data[i*32 +: 32] = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr(); reset = 1; in_valid = 1; br_op = 3'd7; pc = 32'h1234; wa = 5'd3;
    #1 check("rst_redirect", redirect, 0);
    tick();
    check("rst_ex_valid", ex_valid, 0);
    check("rst_ex_pc", ex_pc, 0);
    check("rst_ex_wa", ex_wa, 0);
    // regfile writes, then read with same-cycle write-through
    clr(); wb_we = 1; wb_addr = 5'd5; wb_data = 32'h11;
    tick();
    check("idle_bubble", ex_valid, 0);
    clr(); in_valid = 1; rs = 5'd5; rt = 5'd6; wa = 5'd9; tnew = 3'd2; imm = 32'h44; pc = 32'h100;
    wb_we = 1; wb_addr = 5'd6; wb_data = 32'h22;
    #1 check("rf_stall", stall, 0);
    tick();
    check("rf_valid", ex_valid, 1);
    check("rf_rs_data", ex_rs_data, 32'h11);
    check("wt_rt_data", ex_rt_data, 32'h22);
    check("ld_wa", ex_wa, 9);
    check("ld_tnew", ex_tnew, 2);
    check("ld_rs_rt", {ex_rs, ex_rt}, {5'd5, 5'd6});
    check("ld_imm_pc", {ex_imm, ex_pc}, {32'h44, 32'h100});
    // youngest of two ready sources wins; rt from source 2
    clr(); in_valid = 1; rs = 5'd5; rt = 5'd6; tuse_rs = 0; tuse_rt = 0;
    src(0, 5'd5, 0, 32'hAA); src(1, 5'd5, 0, 32'hBB); src(2, 5'd6, 0, 32'hCC);
    #1 check("fwd_stall", stall, 0);
    tick();
    check("fwd_rs_src0", ex_rs_data, 32'hAA);
    check("fwd_rt_src2", ex_rt_data, 32'hCC);
    // load-use hazard; the older ready source must not hide it
    clr(); in_valid = 1; rs = 5'd8; tuse_rs = 3'd1; wa = 5'd3; tnew = 3'd1;
    src(0, 5'd8, 2, 32'h77); src(1, 5'd8, 0, 32'h55);
    #1 check("haz_stall_t2", stall, 1);
    tick();
    check("haz_bubble_valid", ex_valid, 0);
    check("haz_bubble_wa", ex_wa, 0);
    check("haz_bubble_tnew", ex_tnew, 0);
    src(0, 5'd8, 1, 32'h77);
    #1 check("haz_t1_eq_tuse", stall, 0);
    tuse_rs = 3'd0;
    #1 check("haz_stall_t1", stall, 1);
    tick();
    check("haz_bubble2", ex_valid, 0);
    src(0, 5'd8, 0, 32'h77);
    #1 check("haz_clear", stall, 0);
    tick();
    check("haz_fwd_valid", ex_valid, 1);
    check("haz_fwd_data", ex_rs_data, 32'h77);
    clr(); in_valid = 1; rs = 5'd4; tuse_rs = 3'd7; src(0, 5'd4, 3'd5, 32'h0);
    #1 check("tuse7_no_stall", stall, 0);
    // branches
    clr(); in_valid = 1; rs = 5'd1; rt = 5'd2; pc = 32'h3000; imm = 32'h3; br_op = 3'd1;
    src(0, 5'd1, 0, 32'h7); src(1, 5'd2, 0, 32'h7);
    #1 check("beq_redirect", redirect, 1);
    check("beq_pc", redirect_pc, 32'h3010);
    br_op = 3'd2;
    #1 check("bne_redirect", redirect, 0);
    check("bne_pc_zero", redirect_pc, 0);
    br_op = 3'd5; src(0, 5'd1, 0, 32'hFFFF_FFFF);
    #1 check("bltz_redirect", redirect, 1);
    check("bltz_pc", redirect_pc, 32'h3010);
    br_op = 3'd6;
    #1 check("bgez_neg", redirect, 0);
    br_op = 3'd4; src(0, 5'd1, 0, 32'h0);
    #1 check("bgtz_zero", redirect, 0);
    br_op = 3'd3;
    #1 check("blez_zero", redirect, 1);
    imm = 32'hFFFF_FFFE;
    #1 check("blez_back_pc", redirect_pc, 32'h2FFC);
    clr(); in_valid = 1; rs = 5'd1; br_op = 3'd7; pc = 32'h5000; src(0, 5'd1, 0, 32'h4000);
    #1 check("jr_redirect", redirect, 1);
    check("jr_pc", redirect_pc, 32'h4000);
    tick();
    check("jr_ex_rs_data", ex_rs_data, 32'h4000);
    // hold dominates stall and flush
    clr(); in_valid = 1; rs = 5'd1; tuse_rs = 0; br_op = 3'd7; ex_hold = 1; flush = 1;
    pc = 32'h6000; src(0, 5'd1, 3, 32'h9);
    #1 check("hold_stall", stall, 1);
    check("hold_redirect", redirect, 0);
    tick();
    check("hold_valid", ex_valid, 1);
    check("hold_rs_data", ex_rs_data, 32'h4000);
    check("hold_pc", ex_pc, 32'h5000);
    clr(); in_valid = 1; rs = 5'd1; br_op = 3'd7; flush = 1; pc = 32'h6000; src(0, 5'd1, 0, 32'h9);
    #1 check("flush_redirect", redirect, 0);
    tick();
    check("flush_valid", ex_valid, 0);
    check("flush_rs_data", ex_rs_data, 0);
    // register 0 ignores writes and never matches a source
    clr(); wb_we = 1; wb_addr = 5'd0; wb_data = 32'h5;
    tick();
    clr(); in_valid = 1; rs = 5'd0; tuse_rs = 0; src(0, 5'd0, 3, 32'hDEAD);
    wb_we = 1; wb_addr = 5'd0; wb_data = 32'h5;
    #1 check("r0_stall", stall, 0);
    tick();
    check("r0_valid", ex_valid, 1);
    check("r0_rs_data", ex_rs_data, 0);
    // reset beats hold and clears the regfile
    clr(); reset = 1; ex_hold = 1;
    tick();
    check("rst_over_hold", ex_valid, 0);
    clr(); in_valid = 1; rs = 5'd5;
    tick();
    check("rst_rf_clear", ex_rs_data, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
